// File: rtl/motor_pkg.sv
// Shared motor-control types, default PWM timing and the duty-ramp helper.
// Latency: none (declarations and a pure combinational function only).
// Backpressure: not applicable.
package motor_pkg;

    localparam int DUTY_W        = 14;
    localparam int DEF_PERIOD    = 8760;
    localparam int DEF_RAMP_STEP = 146;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RAMP = 2'd1,
        ST_HOLD = 2'd2,
        ST_STOP = 2'd3
    } motor_state_t;

    // Move cur toward tgt by at most step. Each branch only subtracts the
    // smaller value from the larger, so the unsigned result never wraps and
    // never passes tgt.
    function automatic logic [DUTY_W-1:0] step_toward(
        input logic [DUTY_W-1:0] cur,
        input logic [DUTY_W-1:0] tgt,
        input logic [DUTY_W-1:0] step
    );
        logic [DUTY_W-1:0] res;
        res = tgt;
        if (tgt >= cur) begin
            if ((tgt - cur) > step) res = cur + step;
        end else begin
            if ((cur - tgt) > step) res = cur - step;
        end
        return res;
    endfunction

endpackage

// File: rtl/pwm_core.sv
// PWM period counter and comparator with a period-boundary pulse.
// Latency: power is registered, so it follows the counter value by one cycle.
// Backpressure: none; the counter free-runs whenever reset is released.
module pwm_core
    import motor_pkg::*;
#(
    parameter int PERIOD = DEF_PERIOD
) (
    input  logic              m_clock,
    input  logic              p_reset,
    input  logic [DUTY_W-1:0] duty,
    output logic              power,
    output logic              period_end
);

    localparam logic [DUTY_W-1:0] LAST = DUTY_W'(PERIOD - 1);

    logic [DUTY_W-1:0] cnt;

    assign period_end = (cnt == LAST);

    // Free-running period counter, wraps after the boundary cycle.
    always_ff @(posedge m_clock or negedge p_reset) begin
        if (!p_reset) begin
            cnt <= '0;
        end else if (period_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + DUTY_W'(1);
        end
    end

    // Registered compare: duty 0 is constant low, duty PERIOD is constant high.
    always_ff @(posedge m_clock or negedge p_reset) begin
        if (!p_reset) begin
            power <= 1'b0;
        end else begin
            power <= (cnt < duty);
        end
    end

endmodule

// File: rtl/motor_ramp_ctrl.sv
// Motor PWM controller that slews the duty toward a commanded target once per period.
// Latency: commands are accepted on the valid&ready cycle; the duty moves only at period boundaries.
// Backpressure: cmd_ready drops while a ramp-down-and-stop is in progress and during reset.
module motor_ramp_ctrl
    import motor_pkg::*;
#(
    parameter int PERIOD    = DEF_PERIOD,
    parameter int RAMP_STEP = DEF_RAMP_STEP
) (
    input  logic              m_clock,
    input  logic              p_reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DUTY_W-1:0] cmd_duty,
    input  logic              cmd_stop,
    output logic              power,
    output logic              busy,
    output logic              at_target
);

    localparam logic [DUTY_W-1:0] PERIOD_D = DUTY_W'(PERIOD);
    localparam logic [DUTY_W-1:0] STEP_D   = DUTY_W'(RAMP_STEP);

    motor_state_t      state, state_nxt;
    logic [DUTY_W-1:0] target, target_nxt;
    logic [DUTY_W-1:0] duty_cur, duty_nxt;
    logic [DUTY_W-1:0] duty_clamped;
    logic              ready_en;
    logic              period_end;
    logic              accept;

    // ready_en keeps cmd_ready low through reset and opens it on the first edge after release.
    assign cmd_ready    = ready_en && (state != ST_STOP);
    assign accept       = cmd_valid && cmd_ready;
    assign duty_clamped = (cmd_duty > PERIOD_D) ? PERIOD_D : cmd_duty;
    assign busy         = (state == ST_RAMP) || (state == ST_STOP);
    assign at_target    = (state == ST_HOLD);

    pwm_core #(
        .PERIOD (PERIOD)
    ) u_pwm (
        .m_clock    (m_clock),
        .p_reset    (p_reset),
        .duty       (duty_cur),
        .power      (power),
        .period_end (period_end)
    );

    // State, target and duty registers; reset discards any ramp in progress.
    always_ff @(posedge m_clock or negedge p_reset) begin
        if (!p_reset) begin
            state    <= ST_IDLE;
            target   <= '0;
            duty_cur <= '0;
            ready_en <= 1'b0;
        end else begin
            state    <= state_nxt;
            target   <= target_nxt;
            duty_cur <= duty_nxt;
            ready_en <= 1'b1;
        end
    end

    // Command decode first, then the boundary step against the freshly loaded target.
    always_comb begin
        state_nxt  = state;
        target_nxt = target;
        duty_nxt   = duty_cur;

        case (state)
            ST_IDLE: begin
                // A stop while idle has nothing to ramp down.
                if (accept && !cmd_stop) begin
                    target_nxt = duty_clamped;
                    if (duty_clamped != duty_cur) state_nxt = ST_RAMP;
                end
            end
            ST_RAMP, ST_HOLD: begin
                if (accept) begin
                    if (cmd_stop) begin
                        target_nxt = '0;
                        state_nxt  = ST_STOP;
                    end else begin
                        target_nxt = duty_clamped;
                        state_nxt  = (duty_clamped != duty_cur) ? ST_RAMP : ST_HOLD;
                    end
                end
            end
            default: begin
                // ST_STOP: cmd_ready is low, nothing can be accepted.
            end
        endcase

        if (period_end && ((state_nxt == ST_RAMP) || (state_nxt == ST_STOP))) begin
            duty_nxt = step_toward(duty_cur, target_nxt, STEP_D);
            if (duty_nxt == target_nxt) begin
                state_nxt = (state_nxt == ST_RAMP) ? ST_HOLD : ST_IDLE;
            end
        end
    end

endmodule
